// File: rtl/lock_pkg.sv
// -----------------------------------------------------------------------------
// lock_pkg
//   Shared definitions for the unlock controller slice:
//     - state_t : verification FSM states
//     - DIGIT_W : bits per keypad digit
//     - CW()    : code width for a given number of digits
// -----------------------------------------------------------------------------
package lock_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      ENTRY    = 3'd1,
      WAIT_CFM = 3'd2,
      PASS     = 3'd3,
      FAIL     = 3'd4,
      LOCKED   = 3'd5
   } state_t;

   localparam int DIGIT_W = 4;

   // Width in bits of a stored or entered code of 'digits' digits.
   function automatic int CW(input int digits);
      return DIGIT_W * digits;
   endfunction

endpackage

// File: rtl/lock_timer.sv
// -----------------------------------------------------------------------------
// lock_timer
//   Loadable down-counter shared by the PASS hold time and the LOCKED time.
//   A load of N-1 followed by enabled cycles gives exactly N cycles until the
//   state that owns the timer sees zero and leaves.
// Ports
//   clk   : system clock
//   rst   : synchronous active-high reset (count -> 0)
//   load  : load 'value' into the counter (wins over en)
//   en    : decrement by one per cycle while non-zero
//   value : load value
//   zero  : count is zero
// -----------------------------------------------------------------------------
module lock_timer #(
   parameter int W = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         en,
   input  logic [W-1:0] value,
   output logic         zero
);

   logic [W-1:0] cnt_r;

   // Down-counter: load has priority, the count parks at zero instead of wrapping.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r <= {W{1'b0}};
      end else if (load) begin
         cnt_r <= value;
      end else if (en && (cnt_r != {W{1'b0}})) begin
         cnt_r <= cnt_r - W'(1'b1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign zero = (cnt_r == {W{1'b0}});

endmodule

// File: rtl/unlock_ctrl.sv
// -----------------------------------------------------------------------------
// unlock_ctrl
//   Runs one password-verification attempt against the stored code from the
//   setting block: collects digits, compares on confirm, drives unlock, counts
//   consecutive failures and enforces a timed lockout with alarm.
// Ports
//   clk, rst      : clock, synchronous active-high reset
//   set           : setting mode active, aborts an attempt (ignored in LOCKED)
//   check         : start / retry an attempt, manual relock in PASS
//   confirm       : submit the entered code (only honoured in WAIT_CFM)
//   keyboard_en   : one-cycle strobe, keyboard_num valid
//   keyboard_num  : digit value
//   setend        : stored code valid; falling aborts (except in LOCKED)
//   setnum        : stored code, digit0 in the top nibble
//   seat          : entry-progress mask, 1 = digit pending, MSB = digit0
//   unlock        : high in PASS
//   fail_led      : high in FAIL
//   alarm         : high in LOCKED
//   err_cnt       : consecutive failure count, saturates at MAX_TRIES
// -----------------------------------------------------------------------------
module unlock_ctrl
   import lock_pkg::*;
#(
   parameter int DIGITS        = 3,
   parameter int MAX_TRIES     = 3,
   parameter int LOCK_CYCLES   = 1000,
   parameter int UNLOCK_CYCLES = 500
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             set,
   input  logic                             check,
   input  logic                             confirm,
   input  logic                             keyboard_en,
   input  logic [DIGIT_W-1:0]               keyboard_num,
   input  logic                             setend,
   input  logic [CW(DIGITS)-1:0]            setnum,
   output logic [DIGITS-1:0]                seat,
   output logic                             unlock,
   output logic                             fail_led,
   output logic                             alarm,
   output logic [$clog2(MAX_TRIES+1)-1:0]   err_cnt
);

   localparam int CODE_W = CW(DIGITS);
   localparam int EW     = $clog2(MAX_TRIES + 1);
   localparam int IW     = $clog2(DIGITS + 1);
   localparam int T_MAX  = (LOCK_CYCLES > UNLOCK_CYCLES) ? LOCK_CYCLES : UNLOCK_CYCLES;
   localparam int TW     = $clog2(T_MAX + 1);

   localparam logic [EW-1:0]     ERR_MAX  = EW'(MAX_TRIES);
   localparam logic [EW-1:0]     ERR_ONE  = EW'(1'b1);
   localparam logic [IW-1:0]     IDX_LAST = IW'(DIGITS - 1);
   localparam logic [IW-1:0]     IDX_ONE  = IW'(1'b1);
   localparam logic [TW-1:0]     T_UNLOCK = TW'(UNLOCK_CYCLES - 1);
   localparam logic [TW-1:0]     T_LOCK   = TW'(LOCK_CYCLES - 1);
   localparam logic [CODE_W-1:0] DIG_MASK = CODE_W'({DIGIT_W{1'b1}});

   state_t              state_r;
   logic [DIGITS-1:0]   seat_r;
   logic                unlock_r;
   logic                fail_led_r;
   logic                alarm_r;
   logic [EW-1:0]       err_cnt_r;
   logic [CODE_W-1:0]   buf_r;
   logic [IW-1:0]       idx_r;

   logic                abort_s;
   logic                match_s;
   logic                lock_hit_s;
   int                  sh_s;
   logic [CODE_W-1:0]   buf_wr_s;
   logic [DIGITS-1:0]   seat_wr_s;
   logic                t_load_s;
   logic                t_en_s;
   logic [TW-1:0]       t_value_s;
   logic                t_zero_s;

   // Abort, compare, digit-insert and timer-control decode.
   always_comb begin
      abort_s    = 1'b0;
      match_s    = (buf_r == setnum);
      lock_hit_s = (err_cnt_r == (ERR_MAX - ERR_ONE));
      sh_s       = DIGIT_W * (DIGITS - 1 - int'(idx_r));
      buf_wr_s   = (buf_r & ~(DIG_MASK << sh_s)) | (CODE_W'(keyboard_num) << sh_s);
      seat_wr_s  = seat_r & ~(DIGITS'(1'b1) << (DIGITS - 1 - int'(idx_r)));
      t_load_s   = 1'b0;
      t_value_s  = T_LOCK;
      t_en_s     = 1'b0;

      // LOCKED cannot be left by set or a dropped stored code.
      if (state_r != LOCKED) begin
         abort_s = set | ~setend;
      end else begin
         abort_s = 1'b0;
      end

      if (match_s) begin
         t_value_s = T_UNLOCK;
      end else begin
         t_value_s = T_LOCK;
      end

      // Timer is loaded on the same edge the FSM enters PASS or LOCKED.
      if ((state_r == WAIT_CFM) && !abort_s && confirm && (match_s || lock_hit_s)) begin
         t_load_s = 1'b1;
      end else begin
         t_load_s = 1'b0;
      end

      if ((state_r == PASS) || (state_r == LOCKED)) begin
         t_en_s = 1'b1;
      end else begin
         t_en_s = 1'b0;
      end
   end

   lock_timer #(
      .W (TW)
   ) u_timer (
      .clk   (clk),
      .rst   (rst),
      .load  (t_load_s),
      .en    (t_en_s),
      .value (t_value_s),
      .zero  (t_zero_s)
   );

   // Verification FSM with entry buffer, failure counter and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= IDLE;
         seat_r     <= {DIGITS{1'b1}};
         unlock_r   <= 1'b0;
         fail_led_r <= 1'b0;
         alarm_r    <= 1'b0;
         err_cnt_r  <= {EW{1'b0}};
         buf_r      <= {CODE_W{1'b1}};
         idx_r      <= {IW{1'b0}};
      end else if (abort_s) begin
         // set or loss of the stored code: drop the attempt, keep err_cnt.
         state_r    <= IDLE;
         seat_r     <= {DIGITS{1'b1}};
         unlock_r   <= 1'b0;
         fail_led_r <= 1'b0;
         alarm_r    <= 1'b0;
         buf_r      <= {CODE_W{1'b1}};
         idx_r      <= {IW{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               if (check && setend) begin
                  state_r <= ENTRY;
                  seat_r  <= {DIGITS{1'b1}};
                  buf_r   <= {CODE_W{1'b1}};
                  idx_r   <= {IW{1'b0}};
               end else begin
                  state_r <= IDLE;
               end
            end
            ENTRY: begin
               // confirm is deliberately not looked at until WAIT_CFM.
               if (keyboard_en) begin
                  buf_r  <= buf_wr_s;
                  seat_r <= seat_wr_s;
                  idx_r  <= idx_r + IDX_ONE;
                  if (idx_r == IDX_LAST) begin
                     state_r <= WAIT_CFM;
                  end else begin
                     state_r <= ENTRY;
                  end
               end else begin
                  state_r <= ENTRY;
               end
            end
            WAIT_CFM: begin
               if (confirm) begin
                  if (match_s) begin
                     state_r   <= PASS;
                     unlock_r  <= 1'b1;
                     err_cnt_r <= {EW{1'b0}};
                  end else if (lock_hit_s) begin
                     state_r   <= LOCKED;
                     alarm_r   <= 1'b1;
                     err_cnt_r <= ERR_MAX;
                  end else begin
                     state_r    <= FAIL;
                     fail_led_r <= 1'b1;
                     if (err_cnt_r != ERR_MAX) begin
                        err_cnt_r <= err_cnt_r + ERR_ONE;
                     end else begin
                        err_cnt_r <= err_cnt_r;
                     end
                  end
               end else begin
                  state_r <= WAIT_CFM;
               end
            end
            PASS: begin
               // check relocks early; otherwise hold until the timer expires.
               if (check || t_zero_s) begin
                  state_r  <= IDLE;
                  unlock_r <= 1'b0;
               end else begin
                  state_r <= PASS;
               end
            end
            FAIL: begin
               if (check) begin
                  state_r    <= ENTRY;
                  fail_led_r <= 1'b0;
                  seat_r     <= {DIGITS{1'b1}};
                  buf_r      <= {CODE_W{1'b1}};
                  idx_r      <= {IW{1'b0}};
               end else begin
                  state_r <= FAIL;
               end
            end
            LOCKED: begin
               if (t_zero_s) begin
                  state_r   <= IDLE;
                  alarm_r   <= 1'b0;
                  err_cnt_r <= {EW{1'b0}};
               end else begin
                  state_r <= LOCKED;
               end
            end
            default: begin
               state_r    <= IDLE;
               seat_r     <= {DIGITS{1'b1}};
               unlock_r   <= 1'b0;
               fail_led_r <= 1'b0;
               alarm_r    <= 1'b0;
               err_cnt_r  <= {EW{1'b0}};
               buf_r      <= {CODE_W{1'b1}};
               idx_r      <= {IW{1'b0}};
            end
         endcase
      end
   end

   assign seat     = seat_r;
   assign unlock   = unlock_r;
   assign fail_led = fail_led_r;
   assign alarm    = alarm_r;
   assign err_cnt  = err_cnt_r;

endmodule

// File: tb/tb_unlock_ctrl.sv
// -----------------------------------------------------------------------------
// tb_unlock_ctrl
//   Directed bench for unlock_ctrl with DIGITS=3, MAX_TRIES=3, LOCK_CYCLES=8,
//   UNLOCK_CYCLES=4. Outputs are observed 1 time unit after each rising edge
//   as the packed vector {seat, unlock, fail_led, alarm, err_cnt}.
// -----------------------------------------------------------------------------
module tb_unlock_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        set;
   logic        check;
   logic        confirm;
   logic        keyboard_en;
   logic [3:0]  keyboard_num;
   logic        setend;
   logic [11:0] setnum;
   logic [2:0]  seat;
   logic        unlock;
   logic        fail_led;
   logic        alarm;
   logic [1:0]  err_cnt;

   int checks = 0;
   int errors = 0;

   unlock_ctrl #(
      .DIGITS        (3),
      .MAX_TRIES     (3),
      .LOCK_CYCLES   (8),
      .UNLOCK_CYCLES (4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .set          (set),
      .check        (check),
      .confirm      (confirm),
      .keyboard_en  (keyboard_en),
      .keyboard_num (keyboard_num),
      .setend       (setend),
      .setnum       (setnum),
      .seat         (seat),
      .unlock       (unlock),
      .fail_led     (fail_led),
      .alarm        (alarm),
      .err_cnt      (err_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] outs();
      return {seat, unlock, fail_led, alarm, err_cnt};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic press(input logic [3:0] k);
      keyboard_en  = 1'b1;
      keyboard_num = k;
      step();
      keyboard_en  = 1'b0;
   endtask

   task automatic enter3(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
      press(a);
      press(b);
      press(c);
   endtask

   task automatic pulse_check();
      check = 1'b1;
      step();
      check = 1'b0;
   endtask

   task automatic pulse_confirm();
      confirm = 1'b1;
      step();
      confirm = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      checks++;
      if (outs() !== {3'b111, 1'b0, 1'b0, 1'b0, 2'd0}) begin
         errors++;
         $display("FAIL reset_values: got %b expected %b", outs(), {3'b111, 3'b000, 2'd0});
      end
      rst = 1'b0;
      step();
      checks++;
      if (outs() !== {3'b111, 1'b0, 1'b0, 1'b0, 2'd0}) begin
         errors++;
         $display("FAIL idle_after_reset: got %b expected %b", outs(), {3'b111, 3'b000, 2'd0});
      end
   endtask

   task automatic test_pass();
      logic [2:0] seat_exp [4];
      logic [3:0] keys [3];
      seat_exp[0] = 3'b111; seat_exp[1] = 3'b011; seat_exp[2] = 3'b001; seat_exp[3] = 3'b000;
      keys[0] = 4'h5; keys[1] = 4'hA; keys[2] = 4'h3;
      pulse_check();
      checks++;
      if (seat !== seat_exp[0]) begin
         errors++;
         $display("FAIL pass_seat0: got %b expected %b", seat, seat_exp[0]);
      end
      for (int i = 0; i < 3; i++) begin
         press(keys[i]);
         checks++;
         if (seat !== seat_exp[i+1]) begin
            errors++;
            $display("FAIL pass_seat%0d: got %b expected %b", i + 1, seat, seat_exp[i+1]);
         end
      end
      pulse_confirm();
      checks++;
      if (outs() !== {3'b000, 1'b1, 1'b0, 1'b0, 2'd0}) begin
         errors++;
         $display("FAIL pass_enter: got %b expected %b", outs(), {3'b000, 3'b100, 2'd0});
      end
      for (int i = 2; i <= 4; i++) begin
         step();
         checks++;
         if (unlock !== 1'b1) begin
            errors++;
            $display("FAIL pass_hold_cycle%0d: got unlock=%b expected 1", i, unlock);
         end
      end
      step();
      checks++;
      if (outs() !== {3'b000, 1'b0, 1'b0, 1'b0, 2'd0}) begin
         errors++;
         $display("FAIL pass_expire: got %b expected %b", outs(), {3'b000, 3'b000, 2'd0});
      end
   endtask

   task automatic test_fail_retry();
      pulse_check();
      enter3(4'h5, 4'hA, 4'h4);
      pulse_confirm();
      checks++;
      if (outs() !== {3'b000, 1'b0, 1'b1, 1'b0, 2'd1}) begin
         errors++;
         $display("FAIL fail_first: got %b expected %b", outs(), {3'b000, 3'b010, 2'd1});
      end
      step();
      checks++;
      if (outs() !== {3'b000, 1'b0, 1'b1, 1'b0, 2'd1}) begin
         errors++;
         $display("FAIL fail_hold: got %b expected %b", outs(), {3'b000, 3'b010, 2'd1});
      end
      pulse_check();
      checks++;
      if (outs() !== {3'b111, 1'b0, 1'b0, 1'b0, 2'd1}) begin
         errors++;
         $display("FAIL fail_retry_arm: got %b expected %b", outs(), {3'b111, 3'b000, 2'd1});
      end
      enter3(4'h5, 4'hA, 4'h3);
      pulse_confirm();
      checks++;
      if (outs() !== {3'b000, 1'b1, 1'b0, 1'b0, 2'd0}) begin
         errors++;
         $display("FAIL retry_pass: got %b expected %b", outs(), {3'b000, 3'b100, 2'd0});
      end
      pulse_check();
      checks++;
      if (outs() !== {3'b000, 1'b0, 1'b0, 1'b0, 2'd0}) begin
         errors++;
         $display("FAIL manual_relock: got %b expected %b", outs(), {3'b000, 3'b000, 2'd0});
      end
   endtask

   task automatic test_lockout();
      for (int a = 1; a <= 2; a++) begin
         pulse_check();
         enter3(4'h1, 4'h2, 4'h3);
         pulse_confirm();
         checks++;
         if (outs() !== {3'b000, 1'b0, 1'b1, 1'b0, 2'(a)}) begin
            errors++;
            $display("FAIL lock_attempt%0d: got %b expected %b", a, outs(), {3'b000, 3'b010, 2'(a)});
         end
      end
      pulse_check();
      enter3(4'h1, 4'h2, 4'h3);
      pulse_confirm();
      checks++;
      if (outs() !== {3'b000, 1'b0, 1'b0, 1'b1, 2'd3}) begin
         errors++;
         $display("FAIL lock_enter: got %b expected %b", outs(), {3'b000, 3'b001, 2'd3});
      end
      // Hammer every input during the lockout; nothing may change.
      for (int c = 2; c <= 8; c++) begin
         check = 1'b1; confirm = 1'b1; set = 1'b1;
         keyboard_en = 1'b1; keyboard_num = 4'h5;
         step();
         checks++;
         if (outs() !== {3'b000, 1'b0, 1'b0, 1'b1, 2'd3}) begin
            errors++;
            $display("FAIL lock_cycle%0d: got %b expected %b", c, outs(), {3'b000, 3'b001, 2'd3});
         end
      end
      check = 1'b0; confirm = 1'b0; set = 1'b0; keyboard_en = 1'b0;
      step();
      checks++;
      if (outs() !== {3'b000, 1'b0, 1'b0, 1'b0, 2'd0}) begin
         errors++;
         $display("FAIL lock_release: got %b expected %b", outs(), {3'b000, 3'b000, 2'd0});
      end
      pulse_check();
      checks++;
      if (seat !== 3'b111) begin
         errors++;
         $display("FAIL lock_after_idle: got seat=%b expected 111", seat);
      end
      set = 1'b1;
      step();
      set = 1'b0;
   endtask

   task automatic test_corner();
      pulse_check();
      press(4'h5);
      press(4'hA);
      pulse_confirm();
      checks++;
      if (outs() !== {3'b001, 1'b0, 1'b0, 1'b0, 2'd0}) begin
         errors++;
         $display("FAIL early_confirm: got %b expected %b", outs(), {3'b001, 3'b000, 2'd0});
      end
      press(4'h3);
      press(4'h7);
      checks++;
      if (outs() !== {3'b000, 1'b0, 1'b0, 1'b0, 2'd0}) begin
         errors++;
         $display("FAIL fourth_key: got %b expected %b", outs(), {3'b000, 3'b000, 2'd0});
      end
      pulse_confirm();
      checks++;
      if (unlock !== 1'b1) begin
         errors++;
         $display("FAIL fourth_key_match: got unlock=%b expected 1", unlock);
      end
      pulse_check();
      pulse_check();
      press(4'h5);
      press(4'hA);
      confirm = 1'b1;
      press(4'h3);
      confirm = 1'b0;
      checks++;
      if (outs() !== {3'b000, 1'b0, 1'b0, 1'b0, 2'd0}) begin
         errors++;
         $display("FAIL coincident_confirm: got %b expected %b", outs(), {3'b000, 3'b000, 2'd0});
      end
      step();
      pulse_confirm();
      checks++;
      if (unlock !== 1'b1) begin
         errors++;
         $display("FAIL coincident_later: got unlock=%b expected 1", unlock);
      end
      pulse_check();
   endtask

   task automatic test_abort();
      pulse_check();
      press(4'h5);
      set = 1'b1;
      check = 1'b1;
      step();
      set = 1'b0;
      check = 1'b0;
      checks++;
      if (outs() !== {3'b111, 1'b0, 1'b0, 1'b0, 2'd0}) begin
         errors++;
         $display("FAIL set_abort: got %b expected %b", outs(), {3'b111, 3'b000, 2'd0});
      end
      press(4'h5);
      checks++;
      if (seat !== 3'b111) begin
         errors++;
         $display("FAIL set_abort_idle: got seat=%b expected 111", seat);
      end
      pulse_check();
      enter3(4'h5, 4'hA, 4'h3);
      pulse_confirm();
      setend = 1'b0;
      step();
      checks++;
      if ({unlock, fail_led, alarm, err_cnt} !== 5'b000_00) begin
         errors++;
         $display("FAIL setend_drop: got %b expected 00000", {unlock, fail_led, alarm, err_cnt});
      end
      pulse_check();
      press(4'h5);
      checks++;
      if (seat !== 3'b111) begin
         errors++;
         $display("FAIL check_no_setend: got seat=%b expected 111", seat);
      end
      setend = 1'b1;
      for (int a = 1; a <= 3; a++) begin
         pulse_check();
         enter3(4'h0, 4'h0, 4'h0);
         pulse_confirm();
      end
      step();
      step();
      checks++;
      if (alarm !== 1'b1) begin
         errors++;
         $display("FAIL lock_before_rst: got alarm=%b expected 1", alarm);
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++;
      if (outs() !== {3'b111, 1'b0, 1'b0, 1'b0, 2'd0}) begin
         errors++;
         $display("FAIL rst_in_lock: got %b expected %b", outs(), {3'b111, 3'b000, 2'd0});
      end
      pulse_check();
      enter3(4'h5, 4'hA, 4'h3);
      pulse_confirm();
      checks++;
      if (outs() !== {3'b000, 1'b1, 1'b0, 1'b0, 2'd0}) begin
         errors++;
         $display("FAIL pass_after_rst: got %b expected %b", outs(), {3'b000, 3'b100, 2'd0});
      end
   endtask

   initial begin
      rst          = 1'b1;
      set          = 1'b0;
      check        = 1'b0;
      confirm      = 1'b0;
      keyboard_en  = 1'b0;
      keyboard_num = 4'h0;
      setend       = 1'b1;
      setnum       = 12'h5A3;
      test_reset();
      test_pass();
      test_fail_retry();
      test_lockout();
      test_corner();
      test_abort();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
